// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH     = 32;
    localparam int ITER_LAST = 31;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    // Magnitude of an operand; unsigned operations pass it through untouched.
    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v,
                                                input logic signedOp);
        return (signedOp && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Datapath for the iterative unit: one radix-2 shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle on a 64-bit register.
// Multiply leaves {hi, lo} of the product; divide leaves {remainder, quotient}.
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 isMul,
    input  logic [WIDTH-1:0]     opA,
    input  logic [WIDTH-1:0]     opB,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0] operand;
    logic             mulMode;
    logic [WIDTH:0]   addSum;
    logic             borrow;
    logic [WIDTH-1:0] remNext;
    logic             take;

    // Next-step arithmetic. The shifted partial remainder is 33 bits; when its
    // top bit is set it always exceeds the divisor, so a 32-bit trial suffices.
    always_comb begin
        addSum            = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        {borrow, remNext} = {1'b0, acc[2*WIDTH-2:WIDTH-1]} - {1'b0, operand};
        take              = acc[2*WIDTH-1] | ~borrow;
    end

    // Operand capture on load, then one iteration per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            operand <= '0;
            mulMode <= 1'b0;
        end else if (load) begin
            mulMode <= isMul;
            if (isMul) begin
                operand <= opA;
                acc     <= {{WIDTH{1'b0}}, opB};
            end else begin
                operand <= opB;
                acc     <= {{WIDTH{1'b0}}, opA};
            end
        end else if (step) begin
            if (mulMode) begin
                acc <= {addSum, acc[WIDTH-1:1]};
            end else if (take) begin
                acc <= {remNext, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc <= {acc[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences the iterative core and
// stalls dependent instructions while an operation is in flight.
//
//   state | meaning
//   IDLE  | waiting; mt*, divide-by-zero complete here in one edge
//   MUL   | 32 shift-add iterations
//   DIV   | 32 shift-subtract iterations
//   FIX   | sign correction, HI/LO write, Done pulse
module ex_muldiv_unit #(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiLoRead,
    input  logic             Flush,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             DivByZero
);
    import muldiv_pkg::*;

    state_t             state;
    logic [4:0]         count;
    logic               negRes;
    logic               negRem;
    logic               resIsMul;
    logic [2*WIDTH-1:0] acc;

    logic               accept;
    logic               isMulOp;
    logic               isDivOp;
    logic               signedOp;
    logic               divZero;
    logic               coreLoad;
    logic               coreStep;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Operation decode and sign-corrected results for the FIX state.
    always_comb begin
        accept   = Start && !Flush && (state == IDLE);
        isMulOp  = (Op == OP_MULT) || (Op == OP_MULTU);
        isDivOp  = (Op == OP_DIV)  || (Op == OP_DIVU);
        signedOp = (Op == OP_MULT) || (Op == OP_DIV);
        divZero  = (B == '0);
        coreLoad = accept && (isMulOp || (isDivOp && !divZero));
        coreStep = (state == MUL) || (state == DIV);
        magA     = absVal(A, signedOp);
        magB     = absVal(B, signedOp);
        prod     = negRes ? -acc : acc;
        quot     = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    assign Stall = Busy & (HiLoRead | Start);

    muldiv_core uCore (
        .clk   (Clk),
        .rst   (Rst),
        .load  (coreLoad),
        .step  (coreStep),
        .isMul (isMulOp),
        .opA   (magA),
        .opB   (magB),
        .acc   (acc)
    );

    // Sequencer with registered HI/LO and status outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            count     <= '0;
            negRes    <= 1'b0;
            negRem    <= 1'b0;
            resIsMul  <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (isMulOp) begin
                            state    <= MUL;
                            Busy     <= 1'b1;
                            count    <= '0;
                            resIsMul <= 1'b1;
                            negRes   <= signedOp && (A[WIDTH-1] ^ B[WIDTH-1]);
                            negRem   <= 1'b0;
                        end else if (isDivOp && divZero) begin
                            Hi        <= A;
                            Lo        <= '1;
                            Done      <= 1'b1;
                            DivByZero <= 1'b1;
                        end else if (isDivOp) begin
                            state    <= DIV;
                            Busy     <= 1'b1;
                            count    <= '0;
                            resIsMul <= 1'b0;
                            negRes   <= signedOp && (A[WIDTH-1] ^ B[WIDTH-1]);
                            negRem   <= signedOp && A[WIDTH-1];
                        end else if (Op == OP_MTHI) begin
                            Hi <= A;
                        end else if (Op == OP_MTLO) begin
                            Lo <= A;
                        end
                    end
                end
                MUL, DIV: begin
                    if (Flush) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        count <= '0;
                    end else if (count == 5'(ITER_LAST)) begin
                        state <= FIX;
                        count <= '0;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    if (!Flush) begin
                        Done <= 1'b1;
                        if (resIsMul) begin
                            Hi <= prod[2*WIDTH-1:WIDTH];
                            Lo <= prod[WIDTH-1:0];
                        end else begin
                            Hi <= rem;
                            Lo <= quot;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: issued mul/div operations push their
// expected HI/LO into a queue; a monitor pops and compares on every Done.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiLoRead;
    logic        Flush;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic        DivByZero;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    exp_t mon;

    always #5 Clk = ~Clk;

    ex_muldiv_unit dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .HiLoRead  (HiLoRead),
        .Flush     (Flush),
        .Hi        (Hi),
        .Lo        (Lo),
        .Busy      (Busy),
        .Stall     (Stall),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Rst === 1'b0 && Done === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected Done", 64'd1, 64'd0);
            end else begin
                mon = expQ.pop_front();
                check("Hi on Done", 64'(Hi), 64'(mon.hi));
                check("Lo on Done", 64'(Lo), 64'(mon.lo));
                check("DivByZero on Done", 64'(DivByZero), 64'(mon.dbz));
            end
        end
    end

    task automatic pushExp(input logic [31:0] h, input logic [31:0] l, input logic z);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.dbz = z;
        expQ.push_back(e);
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo,
                         input logic eDbz, input int eBusy);
        int n;
        pushExp(eHi, eLo, eDbz);
        @(posedge Clk); #1;
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        n = 0;
        @(negedge Clk);
        while (Busy === 1'b1 && n < 100) begin
            n++;
            @(negedge Clk);
        end
        check({name, " busy cycles"}, 64'(n), 64'(eBusy));
        check({name, " Done pulse"}, 64'(Done), 64'd1);
        @(negedge Clk);
        check({name, " Done one cycle"}, 64'(Done), 64'd0);
    endtask

    task automatic mtOp(input logic [2:0] op, input logic [31:0] a);
        @(posedge Clk); #1;
        Start = 1'b1; Op = op; A = a;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(negedge Clk);
        if (op == OP_MTHI) check("MTHI value", 64'(Hi), 64'(a));
        else               check("MTLO value", 64'(Lo), 64'(a));
        check("mt Busy low", 64'(Busy), 64'd0);
    endtask

    initial begin
        int n;
        int stallBad;
        Rst = 1'b1; Start = 1'b0; Op = 3'b000; A = '0; B = '0;
        HiLoRead = 1'b0; Flush = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset Hi", 64'(Hi), 64'd0);
        check("reset Lo", 64'(Lo), 64'd0);
        check("reset Busy", 64'(Busy), 64'd0);
        check("reset Done", 64'(Done), 64'd0);
        check("reset DivByZero", 64'(DivByZero), 64'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        runOp("MULT -3*7",     OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
        runOp("MULTU max*max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        runOp("DIVU 7/2",      OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 33);
        runOp("DIV -7/2",      OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        runOp("DIV 7/-2",      OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33);
        runOp("DIV min/-1",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33);
        runOp("MULT carry",    OP_MULT,  32'h00012345, 32'h00010000, 32'h00000001, 32'h23450000, 1'b0, 33);
        runOp("DIVU 100/7",    OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33);
        runOp("DIV 5/0",       OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 0);

        mtOp(OP_MTHI, 32'h12345678);
        mtOp(OP_MTLO, 32'h9ABCDEF0);
        @(posedge Clk); #1;
        Start = 1'b1; Op = 3'b110; A = 32'hCAFEF00D;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(negedge Clk);
        check("ignored op Hi", 64'(Hi), 64'h12345678);
        check("ignored op Lo", 64'(Lo), 64'h9ABCDEF0);
        check("ignored op Busy", 64'(Busy), 64'd0);

        // Stall and ignored second Start while busy.
        mtOp(OP_MTHI, 32'h11111111);
        pushExp(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        @(posedge Clk); #1;
        Start = 1'b1; Op = OP_MULT; A = 32'hFFFFFFFF; B = 32'd2;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (5) @(posedge Clk); #1;
        HiLoRead = 1'b1; Start = 1'b1; Op = OP_MTHI; A = 32'hDEADBEEF;
        n = 0; stallBad = 0;
        @(negedge Clk);
        while (Busy === 1'b1 && n < 100) begin
            if (Stall !== 1'b1) stallBad++;
            if (n == 3) Start = 1'b0;
            n++;
            @(negedge Clk);
        end
        check("stall cycles low while busy", 64'(stallBad), 64'd0);
        check("stall window length", 64'(n), 64'd28);
        check("Stall in Done cycle", 64'(Stall), 64'd0);
        check("Done in stall test", 64'(Done), 64'd1);
        check("MFHI in Done cycle", 64'(Hi), 64'hFFFFFFFF);
        HiLoRead = 1'b0;
        @(negedge Clk);
        check("Hi after ignored Start", 64'(Hi), 64'hFFFFFFFF);

        // Flush mid-multiply.
        @(posedge Clk); #1;
        Start = 1'b1; Op = OP_MULTU; A = 32'd3; B = 32'd5;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clk); #1;
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0;
        @(negedge Clk);
        check("flush Busy low", 64'(Busy), 64'd0);
        check("flush Hi kept", 64'(Hi), 64'hFFFFFFFF);
        check("flush Lo kept", 64'(Lo), 64'hFFFFFFFE);
        repeat (40) @(negedge Clk);
        check("flush stays idle", 64'(Busy), 64'd0);

        // Flush beats Start in IDLE.
        @(posedge Clk); #1;
        Start = 1'b1; Op = OP_MTLO; A = 32'h55555555; Flush = 1'b1;
        @(posedge Clk); #1;
        Op = OP_DIV; A = 32'd9; B = 32'd0;
        @(posedge Clk); #1;
        Start = 1'b0; Flush = 1'b0;
        @(negedge Clk);
        check("flush+MTLO Lo kept", 64'(Lo), 64'hFFFFFFFE);
        check("flush+DIV0 Hi kept", 64'(Hi), 64'hFFFFFFFF);
        check("flush+Start Busy", 64'(Busy), 64'd0);

        // Asynchronous reset mid-divide.
        @(posedge Clk); #1;
        Start = 1'b1; Op = OP_DIVU; A = 32'd100; B = 32'd3;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (8) @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("async reset Hi", 64'(Hi), 64'd0);
        check("async reset Lo", 64'(Lo), 64'd0);
        check("async reset Busy", 64'(Busy), 64'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        runOp("DIVU after reset", OP_DIVU, 32'd100, 32'd3, 32'd1, 32'd33, 1'b0, 33);

        repeat (2) @(negedge Clk);
        check("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
